lut_cfg_loader: RTL and testbench

Serial configuration loader for one fracturable dual-output LUT (two INPUTS-input LUTs plus a fracture bit). It accepts configuration one bit per handshake, assembles the full `{use_fracture, first_lut, second_lut}` word, and issues a single-cycle `comb_set` commit so the LUT captures the word atomically. It sits between the fabric configuration chain and each LUT instance in a CLB.

---
 rtl/lut_cfg_loader.sv | 134 +++++++++++++
 tb/tb_lut_cfg_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_loader.sv
// Serial loader for one fracturable dual-output LUT: collects {use_fracture, first_lut, second_lut}
// one bit per beat, then pulses comb_set once. Optional trailing parity bit: define LUT_CFG_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | accepting payload bits, MSB (fracture bit) first
// CHECK  | accepting the even-parity bit (LUT_CFG_PARITY_EN only)
// COMMIT | comb_set high for one cycle, config_out held
module lut_cfg_loader #(
    parameter int  INPUTS   = 4,
    parameter int  MEM_SIZE = 2**INPUTS,
    localparam int CFG_W    = 2*MEM_SIZE+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic [CFG_W-1:0] config_out,
    output logic             comb_set,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CNT_W = $clog2(CFG_W+1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef LUT_CFG_PARITY_EN
        CHECK  = 2'd2,
`endif
        COMMIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q;
`ifdef LUT_CFG_PARITY_EN
    logic               err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == COMMIT);
`ifdef LUT_CFG_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef LUT_CFG_PARITY_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
`ifdef LUT_CFG_PARITY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // A restart wins over a beat in the same cycle; the old word is simply overwritten later.
                if (start) begin
                    cnt_d = '0;
`ifdef LUT_CFG_PARITY_EN
                    err_d = 1'b0;
`endif
                end else if (cfg_valid) begin
                    sr_d  = {sr_q[CFG_W-2:0], cfg_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CFG_W-1)) begin
`ifdef LUT_CFG_PARITY_EN
                        state_d = CHECK;
`else
                        state_d = COMMIT;
`endif
                    end
                end
            end
`ifdef LUT_CFG_PARITY_EN
            CHECK: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (cfg_valid) begin
                    if ((^sr_q ^ cfg_bit) == 1'b0) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LUT_CFG_PARITY_EN
    assign cfg_ready = (state_q == SHIFT) || (state_q == CHECK);
    assign err       = err_q;
`else
    assign cfg_ready = (state_q == SHIFT);
    assign err       = 1'b0;
`endif
    assign comb_set   = (state_q == COMMIT);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign config_out = sr_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench for lut_cfg_loader (INPUTS=4, CFG_W=33); follows LUT_CFG_PARITY_EN when defined.
module tb_lut_cfg_loader;
    localparam int CFG_W = 33;
`ifdef LUT_CFG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_bit = 1'b0;
    logic             cfg_ready;
    logic [CFG_W-1:0] config_out;
    logic             comb_set;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;
    int commits = 0;
    logic prev_cs = 1'b0;
    // Last CFG_W bits the loader should have accepted, oldest in the MSB.
    logic [CFG_W-1:0] hist = '0;

    lut_cfg_loader #(.INPUTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .config_out(config_out), .comb_set(comb_set), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // done must be exactly comb_set delayed by one cycle.
    always @(negedge clk) begin
        if (comb_set === 1'b1) commits++;
        if (rst_n) chk("done_follows_comb_set", {63'd0, done}, {63'd0, prev_cs});
        prev_cs = comb_set;
    end

    task automatic run_load(input logic [CFG_W-1:0] w, input bit flip, input bit gaps,
                            input bit do_start, input bit b2b,
                            input bit exp_commit, input bit exp_err, input string name);
        int c0;
        if (do_start) begin
            start = 1'b1; cfg_valid = 1'b0;
            @(negedge clk);
            start = 1'b0;
        end
        chk({name, "_busy_shift"}, {63'd0, busy}, 64'd1);
        chk({name, "_ready_shift"}, {63'd0, cfg_ready}, 64'd1);
        c0 = commits;
        for (int i = CFG_W-1; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin cfg_valid = 1'b0; @(negedge clk); end
            cfg_valid = 1'b1; cfg_bit = w[i];
            hist = {hist[CFG_W-2:0], w[i]};
            @(negedge clk);
        end
`ifdef LUT_CFG_PARITY_EN
        if (gaps) repeat ($urandom_range(0, 3)) begin cfg_valid = 1'b0; @(negedge clk); end
        cfg_valid = 1'b1; cfg_bit = (^w) ^ flip;
        @(negedge clk);
`endif
        cfg_valid = 1'b0;
        chk({name, "_comb_set"}, {63'd0, comb_set}, {63'd0, exp_commit});
        chk({name, "_config_out"}, {31'd0, config_out}, {31'd0, hist});
        chk({name, "_err"}, {63'd0, err}, {63'd0, exp_err});
        @(negedge clk);
        chk({name, "_done"}, {63'd0, done}, {63'd0, exp_commit});
        chk({name, "_comb_set_gone"}, {63'd0, comb_set}, 64'd0);
        chk({name, "_busy_low"}, {63'd0, busy}, 64'd0);
        chk({name, "_config_hold"}, {31'd0, config_out}, {31'd0, hist});
        if (b2b) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_commit_count"}, 64'(commits - c0), {63'd0, exp_commit});
        chk({name, "_err_sticky"}, {63'd0, err}, {63'd0, exp_err && !b2b});
    endtask

    typedef struct {
        logic [CFG_W-1:0] word;
        bit               flip;
        bit               gaps;
        bit               exp_commit;
        bit               exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{33'h1_8000_00FF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{33'h1_8000_00FF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{33'h0_0000_0001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{33'h0_0000_0001, 1'b1, 1'b0, !PAR, PAR};
        vecs[4] = '{33'h1_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{33'h0_0000_0000, 1'b1, 1'b1, !PAR, PAR};
        vecs[6] = '{33'h0_A5A5_5A5A, 1'b0, 1'b0, 1'b1, 1'b0};

        #3;
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        chk("rst_config_out", {31'd0, config_out}, 64'd0);
        chk("rst_comb_set", {63'd0, comb_set}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cfg_valid = 1'b1; cfg_bit = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", {63'd0, cfg_ready}, 64'd0);
            chk("idle_config_out", {31'd0, config_out}, 64'd0);
            chk("idle_busy", {63'd0, busy}, 64'd0);
        end
        cfg_valid = 1'b0;

        for (int i = 0; i < 7; i++)
            run_load(vecs[i].word, vecs[i].flip, vecs[i].gaps, 1'b1, 1'b0,
                     vecs[i].exp_commit, vecs[i].exp_err, $sformatf("vec%0d", i));

        // start in the cycle done is high opens the next load directly
        run_load(33'h0_1234_5678, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "b2b_first");
        run_load(33'h1_0F0F_F0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_second");

        // restart after 10 beats; the beat alongside start must be dropped
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'($urandom_range(0, 1));
            hist = {hist[CFG_W-2:0], cfg_bit};
            @(negedge clk);
        end
        start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_valid = 1'b0;
        run_load(33'h0_FFFF_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "restart");

        // reset at beat 20: immediate clear, no commit
        begin
            int c0;
            c0 = commits;
            start = 1'b1; @(negedge clk); start = 1'b0;
            for (int i = 0; i < 20; i++) begin
                cfg_valid = 1'b1; cfg_bit = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_config_out", {31'd0, config_out}, 64'd0);
            chk("midrst_busy", {63'd0, busy}, 64'd0);
            chk("midrst_ready", {63'd0, cfg_ready}, 64'd0);
            chk("midrst_comb_set", {63'd0, comb_set}, 64'd0);
            chk("midrst_done", {63'd0, done}, 64'd0);
            chk("midrst_err", {63'd0, err}, 64'd0);
            hist = '0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            cfg_valid = 1'b0;
            @(negedge clk);
            chk("midrst_no_commit", 64'(commits - c0), 64'd0);
            chk("midrst_after_config_out", {31'd0, config_out}, 64'd0);
        end

        for (int r = 0; r < 20; r++) begin
            logic [CFG_W-1:0] w;
            bit f;
            w = {1'($urandom_range(0, 1)), $urandom()};
            f = PAR && ($urandom_range(0, 3) == 0);
            run_load(w, f, 1'b1, 1'b1, 1'b0, !f, f, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
